// File: rtl/trx_seq_pkg.sv
// -----------------------------------------------------------------------------
// trx_seq_pkg
// Shared definitions for the transceiver frame sequencer.
//   STATE_W : width of the externally visible state encoding
//   state_e : sequencer states; the numeric values appear on outState and are
//             part of the block's external contract, so they are fixed here.
// -----------------------------------------------------------------------------
package trx_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_TX_FETCH = 3'd1,
        ST_TX_SEND  = 3'd2,
        ST_RX_RUN   = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } state_e;

endpackage

// File: rtl/trx_timeout_counter.sv
// -----------------------------------------------------------------------------
// trx_timeout_counter
// Idle-cycle counter shared by the TX fetch wait and the RX bit wait.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   clear_i  : restart the count at zero (wins over inc_i)
//   inc_i    : count one idle cycle
//   last_o   : the next increment reaches TIMEOUT; the caller combines this
//              with its own increment request to leave the waiting state on
//              exactly the TIMEOUT-th consecutive idle cycle
// -----------------------------------------------------------------------------
module trx_timeout_counter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic last_o
);

    localparam logic [TO_W-1:0] CNT_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] CNT_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_ONE   = TO_W'(1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_LIMIT)) begin
            // Saturate so a caller that ignores last_o cannot wrap around.
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Depends only on the register, so no combinational path back to inc_i.
    assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/trx_sequencer.sv
// -----------------------------------------------------------------------------
// trx_sequencer
// Frame-level controller for the transceiver datapath. Paces the TX chain by
// turning coder-ready rising edges into single inFIFO reads, gates valid CDR
// bits into the outFIFO, counts bits per frame and flags timeouts/overflow.
// Ports:
//   inClock / inReset        : clock and synchronous active-low reset
//   inStartTx / inStartRx    : frame start pulses (honoured only in IDLE)
//   inAbort                  : return to IDLE from anywhere, clears the error
//   inFifoEmpty              : inFIFO empty
//   inCoderReady             : coder ready level (rising edge requests a bit)
//   inCdrFlag / inCdrData    : CDR bit valid / recovered bit
//   inOutFifoFull            : outFIFO full
//   outFifoReadEnable        : inFIFO read strobe
//   outCoderEmpty            : low for the single cycle fetched data is valid
//   outOutFifoWriteEnable    : outFIFO write strobe
//   outOutFifoData           : bit written to the outFIFO
//   outBusy                  : sequencer not idle
//   outTxDone / outRxDone    : one-cycle frame completion pulses
//   outError                 : sticky timeout/overflow indication
//   outBitCount              : bits transferred in the current frame
//   outState                 : current state encoding
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module trx_sequencer
    import trx_seq_pkg::*;
#(
    parameter int FRAME_BITS = 32,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = $clog2(FRAME_BITS + 1),
    parameter int TO_W       = $clog2(TIMEOUT + 1)
) (
    input  logic               inClock,
    input  logic               inReset,
    input  logic               inStartTx,
    input  logic               inStartRx,
    input  logic               inAbort,
    input  logic               inFifoEmpty,
    input  logic               inCoderReady,
    input  logic               inCdrFlag,
    input  logic               inCdrData,
    input  logic               inOutFifoFull,
    output logic               outFifoReadEnable,
    output logic               outCoderEmpty,
    output logic               outOutFifoWriteEnable,
    output logic               outOutFifoData,
    output logic               outBusy,
    output logic               outTxDone,
    output logic               outRxDone,
    output logic               outError,
    output logic [CNT_W-1:0]   outBitCount,
    output logic [STATE_W-1:0] outState
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic             ready_prev_q;
    logic             rd_en_q, rd_en_d;
    logic             coder_empty_q, coder_empty_d;
    logic             wr_en_q, wr_en_d;
    logic             wr_data_q, wr_data_d;
    logic             busy_q;
    logic             tx_done_q, tx_done_d;
    logic             rx_done_q, rx_done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    // Remembers which direction the current frame runs so DONE can pick
    // the matching completion pulse.
    logic             tx_path_q, tx_path_d;

    logic             to_clear;
    logic             to_inc;
    logic             to_last;
    logic             ready_edge;

    assign ready_edge = inCoderReady & ~ready_prev_q;

    trx_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk_i   (inClock),
        .rst_ni  (inReset),
        .clear_i (to_clear),
        .inc_i   (to_inc),
        .last_o  (to_last)
    );

    always_comb begin
        state_d       = state_q;
        rd_en_d       = 1'b0;
        coder_empty_d = 1'b1;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        tx_done_d     = 1'b0;
        rx_done_d     = 1'b0;
        error_d       = error_q;
        bit_cnt_d     = bit_cnt_q;
        tx_path_d     = tx_path_q;
        to_clear      = 1'b0;
        to_inc        = 1'b0;

        if (inAbort) begin
            // Strobe defaults above stay deasserted, which is what
            // suppresses anything this cycle would otherwise have issued.
            state_d  = ST_IDLE;
            error_d  = 1'b0;
            to_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (inStartTx) begin
                        state_d   = ST_TX_FETCH;
                        tx_path_d = 1'b1;
                        bit_cnt_d = '0;
                        to_clear  = 1'b1;
                    end else if (inStartRx) begin
                        state_d   = ST_RX_RUN;
                        tx_path_d = 1'b0;
                        bit_cnt_d = '0;
                        to_clear  = 1'b1;
                    end
                end

                ST_TX_FETCH: begin
                    if (ready_edge && !inFifoEmpty) begin
                        rd_en_d  = 1'b1;
                        state_d  = ST_TX_SEND;
                        to_clear = 1'b1;
                    end else if (inFifoEmpty) begin
                        to_inc = 1'b1;
                        if (to_last) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end
                    end
                end

                ST_TX_SEND: begin
                    // The FIFO word read last cycle is now at the coder.
                    coder_empty_d = 1'b0;
                    bit_cnt_d     = bit_cnt_q + CNT_ONE;
                    state_d       = (bit_cnt_q == CNT_LAST) ? ST_DONE : ST_TX_FETCH;
                end

                ST_RX_RUN: begin
                    if (inCdrFlag) begin
                        if (inOutFifoFull) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = inCdrData;
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                            to_clear  = 1'b1;
                            if (bit_cnt_q == CNT_LAST) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        to_inc = 1'b1;
                        if (to_last) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    tx_done_d = tx_path_q;
                    rx_done_d = ~tx_path_q;
                    state_d   = ST_IDLE;
                end

                ST_ERROR: begin
                    error_d = 1'b1;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            state_q       <= ST_IDLE;
            ready_prev_q  <= 1'b0;
            rd_en_q       <= 1'b0;
            coder_empty_q <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_data_q     <= 1'b0;
            busy_q        <= 1'b0;
            tx_done_q     <= 1'b0;
            rx_done_q     <= 1'b0;
            error_q       <= 1'b0;
            bit_cnt_q     <= '0;
            tx_path_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_prev_q  <= inCoderReady;
            rd_en_q       <= rd_en_d;
            coder_empty_q <= coder_empty_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= (state_d != ST_IDLE);
            tx_done_q     <= tx_done_d;
            rx_done_q     <= rx_done_d;
            error_q       <= error_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_path_q     <= tx_path_d;
        end
    end

    assign outFifoReadEnable     = rd_en_q;
    assign outCoderEmpty         = coder_empty_q;
    assign outOutFifoWriteEnable = wr_en_q;
    assign outOutFifoData        = wr_data_q;
    assign outBusy               = busy_q;
    assign outTxDone             = tx_done_q;
    assign outRxDone             = rx_done_q;
    assign outError              = error_q;
    assign outBitCount           = bit_cnt_q;
    assign outState              = state_q;

endmodule

// File: tb/tb_trx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trx_sequencer
// Self-checking bench for trx_sequencer with FRAME_BITS=4, TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge that consumed the previous inputs.
// -----------------------------------------------------------------------------
module tb_trx_sequencer;

    localparam int FB = 4;
    localparam int TO = 8;
    localparam int CW = $clog2(FB + 1);

    logic          clk;
    logic          inReset;
    logic          inStartTx, inStartRx, inAbort, inFifoEmpty, inCoderReady;
    logic          inCdrFlag, inCdrData, inOutFifoFull;
    logic          outFifoReadEnable, outCoderEmpty, outOutFifoWriteEnable;
    logic          outOutFifoData, outBusy, outTxDone, outRxDone, outError;
    logic [CW-1:0] outBitCount;
    logic [2:0]    outState;

    int n_tests = 0;
    int n_fail  = 0;
    int t_rd, t_ce, t_txd, t_rxd;

    trx_sequencer #(
        .FRAME_BITS (FB),
        .TIMEOUT    (TO)
    ) dut (
        .inClock               (clk),
        .inReset               (inReset),
        .inStartTx             (inStartTx),
        .inStartRx             (inStartRx),
        .inAbort               (inAbort),
        .inFifoEmpty           (inFifoEmpty),
        .inCoderReady          (inCoderReady),
        .inCdrFlag             (inCdrFlag),
        .inCdrData             (inCdrData),
        .inOutFifoFull         (inOutFifoFull),
        .outFifoReadEnable     (outFifoReadEnable),
        .outCoderEmpty         (outCoderEmpty),
        .outOutFifoWriteEnable (outOutFifoWriteEnable),
        .outOutFifoData        (outOutFifoData),
        .outBusy               (outBusy),
        .outTxDone             (outTxDone),
        .outRxDone             (outRxDone),
        .outError              (outError),
        .outBitCount           (outBitCount),
        .outState              (outState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // One vector = inputs applied before an edge plus outputs expected after it.
    // vin : {startTx,startRx,abort,fifoEmpty,ready,flag,data,full}
    // ef  : {rd,coderEmpty,wr,wrData,busy,txDone,rxDone,error}
    typedef struct {
        logic [7:0] vin;
        logic [7:0] ef;
        int         cnt;
        int         st;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic [7:0] vin, input logic [7:0] ef,
                                input int cnt, input int st);
        vec_t v;
        v.vin = vin;
        v.ef  = ef;
        v.cnt = cnt;
        v.st  = st;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t_rd  += int'(outFifoReadEnable);
        t_ce  += int'(!outCoderEmpty);
        t_txd += int'(outTxDone);
        t_rxd += int'(outRxDone);
    endtask

    task automatic clear_inputs();
        inStartTx     = 1'b0;
        inStartRx     = 1'b0;
        inAbort       = 1'b0;
        inFifoEmpty   = 1'b0;
        inCoderReady  = 1'b0;
        inCdrFlag     = 1'b0;
        inCdrData     = 1'b0;
        inOutFifoFull = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rd"},     outFifoReadEnable,     0);
        chk({tag, " cempty"}, outCoderEmpty,         1);
        chk({tag, " wr"},     outOutFifoWriteEnable, 0);
        chk({tag, " busy"},   outBusy,               0);
        chk({tag, " txdone"}, outTxDone,             0);
        chk({tag, " rxdone"}, outRxDone,             0);
        chk({tag, " error"},  outError,              0);
        chk({tag, " count"},  outBitCount,           0);
        chk({tag, " state"},  outState,              0);
    endtask

    // TX frame: every bit waits nwait cycles with ready low, then raises ready
    // with data available; the read is seen on the next sample and the coder
    // data window on the one after. Random mode also sprinkles empty-FIFO
    // cycles and ignored RX starts into the waits.
    task automatic tx_frame(input int wait_fix, input string tag);
        int nwait;
        clear_inputs();
        inStartTx = 1'b1;
        step();
        chk({tag, " start state"}, outState, 1);
        chk({tag, " start busy"}, outBusy, 1);
        chk({tag, " start count"}, outBitCount, 0);
        inStartTx = 1'b0;
        for (int b = 0; b < FB; b++) begin
            nwait = (wait_fix >= 0) ? wait_fix : int'($urandom_range(1, 3));
            for (int w = 0; w < nwait; w++) begin
                inCoderReady = 1'b0;
                inFifoEmpty  = (wait_fix >= 0) ? 1'b0 : 1'($urandom_range(0, 1));
                inStartRx    = (wait_fix >= 0) ? 1'b0 : 1'($urandom_range(0, 1));
                step();
                chk($sformatf("%s b%0d wait rd", tag, b), outFifoReadEnable, 0);
                chk($sformatf("%s b%0d wait state", tag, b), outState, 1);
                chk($sformatf("%s b%0d wait count", tag, b), outBitCount, b);
            end
            inStartRx    = 1'b0;
            inFifoEmpty  = 1'b0;
            inCoderReady = 1'b1;
            step();
            chk($sformatf("%s b%0d read", tag, b), outFifoReadEnable, 1);
            chk($sformatf("%s b%0d read cempty", tag, b), outCoderEmpty, 1);
            chk($sformatf("%s b%0d read state", tag, b), outState, 2);
            inCoderReady = 1'b0;
            step();
            chk($sformatf("%s b%0d send cempty", tag, b), outCoderEmpty, 0);
            chk($sformatf("%s b%0d send rd", tag, b), outFifoReadEnable, 0);
            chk($sformatf("%s b%0d send count", tag, b), outBitCount, b + 1);
            chk($sformatf("%s b%0d send state", tag, b), outState, (b == FB - 1) ? 4 : 1);
        end
        step();
        chk({tag, " txdone"}, outTxDone, 1);
        chk({tag, " rxdone"}, outRxDone, 0);
        chk({tag, " end state"}, outState, 0);
        chk({tag, " end busy"}, outBusy, 0);
        chk({tag, " end count"}, outBitCount, FB);
        step();
        chk({tag, " txdone single"}, outTxDone, 0);
        chk({tag, " count hold"}, outBitCount, FB);
    endtask

    // RX frame with random flags/data, rare overflow and abort. The model
    // tracks only bits accepted and consecutive flagless cycles.
    task automatic rx_random_frame(input int f);
        int  n;
        int  idle;
        bit  fin;
        bit  need_abort;
        n = 0;
        idle = 0;
        fin = 1'b0;
        need_abort = 1'b0;
        clear_inputs();
        inStartRx = 1'b1;
        step();
        chk($sformatf("rx%0d start state", f), outState, 3);
        chk($sformatf("rx%0d start count", f), outBitCount, 0);
        inStartRx = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            inCdrFlag     = ($urandom_range(0, 3) != 0);
            inCdrData     = 1'($urandom_range(0, 1));
            inOutFifoFull = ($urandom_range(0, 39) == 0);
            inAbort       = ($urandom_range(0, 39) == 0);
            step();
            if (inAbort) begin
                chk($sformatf("rx%0d abort wr", f), outOutFifoWriteEnable, 0);
                chk($sformatf("rx%0d abort state", f), outState, 0);
                chk($sformatf("rx%0d abort rxdone", f), outRxDone, 0);
                fin = 1'b1;
            end else if (inCdrFlag && inOutFifoFull) begin
                chk($sformatf("rx%0d ovf wr", f), outOutFifoWriteEnable, 0);
                chk($sformatf("rx%0d ovf state", f), outState, 5);
                chk($sformatf("rx%0d ovf error", f), outError, 1);
                fin = 1'b1;
                need_abort = 1'b1;
            end else if (inCdrFlag) begin
                n++;
                idle = 0;
                chk($sformatf("rx%0d wr", f), outOutFifoWriteEnable, 1);
                chk($sformatf("rx%0d data", f), outOutFifoData, inCdrData);
                chk($sformatf("rx%0d count", f), outBitCount, n);
                chk($sformatf("rx%0d state", f), outState, (n == FB) ? 4 : 3);
                if (n == FB) begin
                    clear_inputs();
                    step();
                    chk($sformatf("rx%0d rxdone", f), outRxDone, 1);
                    chk($sformatf("rx%0d txdone", f), outTxDone, 0);
                    chk($sformatf("rx%0d end state", f), outState, 0);
                    chk($sformatf("rx%0d end count", f), outBitCount, FB);
                    fin = 1'b1;
                end
            end else begin
                idle++;
                chk($sformatf("rx%0d idle wr", f), outOutFifoWriteEnable, 0);
                chk($sformatf("rx%0d idle count", f), outBitCount, n);
                if (idle == TO) begin
                    chk($sformatf("rx%0d timeout state", f), outState, 5);
                    chk($sformatf("rx%0d timeout error", f), outError, 1);
                    fin = 1'b1;
                    need_abort = 1'b1;
                end else begin
                    chk($sformatf("rx%0d idle state", f), outState, 3);
                end
            end
        end
        chk($sformatf("rx%0d frame ended within budget", f), int'(fin), 1);
        clear_inputs();
        if (need_abort) begin
            step();
            chk($sformatf("rx%0d error sticky", f), outError, 1);
            inAbort = 1'b1;
            step();
            chk($sformatf("rx%0d recover state", f), outState, 0);
            chk($sformatf("rx%0d recover error", f), outError, 0);
            inAbort = 1'b0;
        end
    endtask

    initial begin
        // RX frame 1,0,1,1, RX overflow, simultaneous start, ignored RX start.
        vecs[0]  = mk(8'b0100_0000, 8'b0100_1000, 0, 3);
        vecs[1]  = mk(8'b0000_0110, 8'b0111_1000, 1, 3);
        vecs[2]  = mk(8'b0000_0100, 8'b0110_1000, 2, 3);
        vecs[3]  = mk(8'b0000_0110, 8'b0111_1000, 3, 3);
        vecs[4]  = mk(8'b0000_0110, 8'b0111_1000, 4, 4);
        vecs[5]  = mk(8'b0000_0000, 8'b0100_0010, 4, 0);
        vecs[6]  = mk(8'b0100_0000, 8'b0100_1000, 0, 3);
        vecs[7]  = mk(8'b0000_0111, 8'b0100_1001, 0, 5);
        vecs[8]  = mk(8'b0000_0000, 8'b0100_1001, 0, 5);
        vecs[9]  = mk(8'b0010_0000, 8'b0100_0000, 0, 0);
        vecs[10] = mk(8'b1100_0000, 8'b0100_1000, 0, 1);
        vecs[11] = mk(8'b0100_0110, 8'b0100_1000, 0, 1);
        vecs[12] = mk(8'b0010_0000, 8'b0100_0000, 0, 0);

        t_rd = 0; t_ce = 0; t_txd = 0; t_rxd = 0;
        clear_inputs();
        inReset = 1'b0;
        inStartTx = 1'b1;
        step();
        step();
        chk_reset_values("reset");
        inReset = 1'b1;
        clear_inputs();
        step();
        chk_reset_values("post-reset idle");

        for (int i = 0; i < 13; i++) begin
            {inStartTx, inStartRx, inAbort, inFifoEmpty,
             inCoderReady, inCdrFlag, inCdrData, inOutFifoFull} = vecs[i].vin;
            step();
            chk($sformatf("vec%0d rd", i),     outFifoReadEnable,     vecs[i].ef[7]);
            chk($sformatf("vec%0d cempty", i), outCoderEmpty,         vecs[i].ef[6]);
            chk($sformatf("vec%0d wr", i),     outOutFifoWriteEnable, vecs[i].ef[5]);
            if (vecs[i].ef[5])
                chk($sformatf("vec%0d wdata", i), outOutFifoData, vecs[i].ef[4]);
            chk($sformatf("vec%0d busy", i),   outBusy,   vecs[i].ef[3]);
            chk($sformatf("vec%0d txdone", i), outTxDone, vecs[i].ef[2]);
            chk($sformatf("vec%0d rxdone", i), outRxDone, vecs[i].ef[1]);
            chk($sformatf("vec%0d error", i),  outError,  vecs[i].ef[0]);
            chk($sformatf("vec%0d count", i),  outBitCount, vecs[i].cnt);
            chk($sformatf("vec%0d state", i),  outState,    vecs[i].st);
        end
        clear_inputs();
        step();

        // TX frame paced every 4 cycles: totals over the whole frame.
        t_rd = 0; t_ce = 0; t_txd = 0; t_rxd = 0;
        tx_frame(2, "txfix");
        chk("txfix read pulses", t_rd, FB);
        chk("txfix coder lows", t_ce, FB);
        chk("txfix done pulses", t_txd, 1);
        chk("txfix rx done pulses", t_rxd, 0);

        // TX underflow: the TIMEOUT-th empty cycle lands in ERROR.
        clear_inputs();
        inStartTx = 1'b1;
        inFifoEmpty = 1'b1;
        step();
        chk("uflow start state", outState, 1);
        inStartTx = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            inCoderReady = (i == 3);
            step();
            chk($sformatf("uflow c%0d rd", i), outFifoReadEnable, 0);
            chk($sformatf("uflow c%0d state", i), outState, (i == TO) ? 5 : 1);
            chk($sformatf("uflow c%0d error", i), outError, (i == TO) ? 1 : 0);
        end
        clear_inputs();
        inStartTx = 1'b1;
        step();
        chk("uflow start ignored", outState, 5);
        inStartTx = 1'b0;
        inAbort = 1'b1;
        step();
        chk("uflow abort state", outState, 0);
        chk("uflow abort error", outError, 0);
        chk("uflow abort busy", outBusy, 0);
        clear_inputs();

        for (int f = 0; f < 30; f++) rx_random_frame(f);
        for (int f = 0; f < 10; f++) tx_frame(-1, $sformatf("txrnd%0d", f));

        // Reset in the middle of an RX frame.
        clear_inputs();
        inStartRx = 1'b1;
        step();
        inStartRx = 1'b0;
        inCdrFlag = 1'b1;
        inCdrData = 1'b1;
        step();
        step();
        chk("midrst count before", outBitCount, 2);
        inReset = 1'b0;
        step();
        chk_reset_values("midrst");
        inReset = 1'b1;
        clear_inputs();
        step();
        chk("midrst stays idle", outState, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
